w0rm_core_writeback: RTL and testbench

Writeback stage directly downstream of the core ALU. Captures every `result_valid` pulse (result, flags, user tag) into a small FIFO and drains entries into the register-file write port under a valid/ack handshake. Commits architectural flags in program order and drives the ALU's `mem_ready` backpressure input.

---
 rtl/w0rm_core_writeback.sv | 122 ++++++++++++
 tb/tb_w0rm_core_writeback.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_core_writeback.sv
// Writeback stage behind the core ALU: buffers ALU results in a small FIFO and
// drains them into the register-file write port, committing flags in order.
module w0rm_core_writeback #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    input  logic [3:0]            alu_flags,
    input  logic [USER_WIDTH-1:0] alu_user_data,
    output logic                  mem_ready,
    output logic                  reg_wr_en,
    output logic [USER_WIDTH-2:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_wr_ack,
    output logic [3:0]            flags_out,
    output logic                  busy,
    output logic                  overflow_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = USER_WIDTH - 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(2);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            flags;
        logic                  we;
        logic [ADDR_W-1:0]     addr;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             head;
    entry_t             new_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   free_slots;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;

    assign new_entry = '{
        data:  alu_result,
        flags: alu_flags,
        we:    alu_user_data[USER_WIDTH-1],
        addr:  alu_user_data[ADDR_W-1:0]
    };

    assign head       = mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign free_slots = DEPTH_C - count;

    // A head that does not write the register file retires without waiting for ack.
    assign pop  = !empty && (!head.we || reg_wr_ack);
    assign push = alu_result_valid && (!full || pop);
    assign drop = alu_result_valid && full && !pop;

    // NOTE: the storage array has no reset; emptiness is defined by count and the
    // pointers, so stale entries are unreachable after reset and need no clearing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers update
    // from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            flags_out    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                flags_out <= head.flags;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // NOTE: each output gets a default before the conditional so no latch is inferred.
    always_comb begin
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        if (!empty) begin
            reg_wr_en   = head.we;
            reg_wr_addr = head.addr;
            reg_wr_data = head.data;
        end
    end

    // Two free slots absorb the result the ALU may issue the cycle after sampling.
    assign mem_ready = (free_slots >= MARGIN_C);
    assign busy      = !empty;

    count_in_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);

endmodule

// File: tb/tb_w0rm_core_writeback.sv
// Directed bench for w0rm_core_writeback: stimulus queues expected writes and
// flag commits, a negedge monitor compares them as the DUT retires entries.
module tb_w0rm_core_writeback;

    localparam int DW = 8;
    localparam int UW = 4;
    localparam int AW = UW - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] alu_result;
    logic          alu_result_valid;
    logic [3:0]    alu_flags;
    logic [UW-1:0] alu_user_data;
    logic          mem_ready;
    logic          reg_wr_en;
    logic [AW-1:0] reg_wr_addr;
    logic [DW-1:0] reg_wr_data;
    logic          reg_wr_ack;
    logic [3:0]    flags_out;
    logic          busy;
    logic          overflow_err;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_wr_q[$];
    logic [3:0]       exp_flag_q[$];
    logic             pend_valid = 1'b0;
    logic [3:0]       pend_flags = '0;

    w0rm_core_writeback #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .alu_flags        (alu_flags),
        .alu_user_data    (alu_user_data),
        .mem_ready        (mem_ready),
        .reg_wr_en        (reg_wr_en),
        .reg_wr_addr      (reg_wr_addr),
        .reg_wr_data      (reg_wr_data),
        .reg_wr_ack       (reg_wr_ack),
        .flags_out        (flags_out),
        .busy             (busy),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle result strobe; dropped results are not expected to retire.
    task automatic push(input logic [DW-1:0] data, input logic [3:0] flags,
                        input logic we, input logic [AW-1:0] addr, input logic dropped);
        alu_result       = data;
        alu_flags        = flags;
        alu_user_data    = {we, addr};
        alu_result_valid = 1'b1;
        if (!dropped) begin
            if (we) exp_wr_q.push_back({addr, data});
            exp_flag_q.push_back(flags);
        end
        tick();
        alu_result_valid = 1'b0;
        alu_result       = '0;
        alu_flags        = '0;
        alu_user_data    = '0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        check("drain_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    // Monitor: a retire happens at the next posedge when the FIFO holds an entry
    // and either no write is requested or the write is acked.
    always @(negedge clk) begin
        if (!reset) begin
            if (pend_valid) begin
                check("flags_commit", 32'(flags_out), 32'(pend_flags));
                pend_valid = 1'b0;
            end
            if (reg_wr_en && reg_wr_ack) begin
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none",
                             reg_wr_addr, reg_wr_data);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(reg_wr_addr), 32'(e[AW+DW-1:DW]));
                    check("wr_data", 32'(reg_wr_data), 32'(e[DW-1:0]));
                end
            end
            if (busy && (!reg_wr_en || reg_wr_ack)) begin
                if (exp_flag_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got flags=0x%0h expected none", flags_out);
                end else begin
                    pend_flags = exp_flag_q.pop_front();
                    pend_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        reset            = 1'b1;
        alu_result       = '0;
        alu_result_valid = 1'b0;
        alu_flags        = '0;
        alu_user_data    = '0;
        reg_wr_ack       = 1'b0;
        tick();
        tick();
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_flags", 32'(flags_out), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        reset = 1'b0;
        tick();

        // Single write with ack held high
        reg_wr_ack = 1'b1;
        push(8'h5A, 4'b0001, 1'b1, 3'd2, 1'b0);
        check("single_en", 32'(reg_wr_en), 32'd1);
        check("single_addr", 32'(reg_wr_addr), 32'd2);
        check("single_data", 32'(reg_wr_data), 32'h5A);
        tick();
        check("single_flags", 32'(flags_out), 32'b0001);
        check("single_busy", 32'(busy), 32'd0);
        tick();

        // Backpressure: three writes held, then drained in order
        reg_wr_ack = 1'b0;
        push(8'h11, 4'b0010, 1'b1, 3'd1, 1'b0);
        check("bp_ready1", 32'(mem_ready), 32'd1);
        push(8'h22, 4'b0100, 1'b1, 3'd2, 1'b0);
        check("bp_ready2", 32'(mem_ready), 32'd1);
        push(8'h33, 4'b0011, 1'b1, 3'd3, 1'b0);
        check("bp_ready3", 32'(mem_ready), 32'd0);
        check("bp_head_data", 32'(reg_wr_data), 32'h11);
        tick();
        check("bp_hold_en", 32'(reg_wr_en), 32'd1);
        check("bp_hold_data", 32'(reg_wr_data), 32'h11);
        check("bp_hold_flags", 32'(flags_out), 32'b0001);
        reg_wr_ack = 1'b1;
        tick();
        check("bp_ready_back", 32'(mem_ready), 32'd1);
        check("bp_next_data", 32'(reg_wr_data), 32'h22);
        wait_idle(10);

        // Entry with we=0 retires without ack or register write
        reg_wr_ack = 1'b0;
        push(8'hC3, 4'b1000, 1'b0, 3'd5, 1'b0);
        check("nowr_en", 32'(reg_wr_en), 32'd0);
        check("nowr_busy", 32'(busy), 32'd1);
        tick();
        check("nowr_drained", 32'(busy), 32'd0);
        check("nowr_flags", 32'(flags_out), 32'b1000);
        tick();

        // Full FIFO with simultaneous push and pop, ten entries to wrap pointers
        reg_wr_ack = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h71 + 8'(i), 4'(i), 1'b1, 3'(i + 1), 1'b0);
        check("full_ready", 32'(mem_ready), 32'd0);
        reg_wr_ack = 1'b1;
        push(8'h77, 4'b0101, 1'b1, 3'd7, 1'b0);
        check("full_pp_busy", 32'(busy), 32'd1);
        check("full_pp_ready", 32'(mem_ready), 32'd0);
        check("full_pp_noerr", 32'(overflow_err), 32'd0);
        for (int i = 0; i < 5; i++) push(8'h78 + 8'(i), 4'(i + 8), 1'b1, 3'(i), 1'b0);
        check("wrap_noerr", 32'(overflow_err), 32'd0);
        check("wrap_head", 32'(reg_wr_data), 32'h79);
        wait_idle(10);

        // Overflow: fifth result with the FIFO full and no pop is dropped
        reg_wr_ack = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h81 + 8'(i), 4'(i + 4), 1'b1, 3'(i + 2), 1'b0);
        push(8'h85, 4'b1111, 1'b1, 3'd6, 1'b1);
        check("ovf_set", 32'(overflow_err), 32'd1);
        check("ovf_head", 32'(reg_wr_data), 32'h81);
        reg_wr_ack = 1'b1;
        wait_idle(10);
        check("ovf_sticky", 32'(overflow_err), 32'd1);
        check("ovf_ready", 32'(mem_ready), 32'd1);

        // Asynchronous reset with two writes pending
        reg_wr_ack = 1'b0;
        push(8'hA1, 4'b0110, 1'b1, 3'd1, 1'b0);
        push(8'hA2, 4'b1001, 1'b1, 3'd2, 1'b0);
        #2;
        reset = 1'b1;
        exp_wr_q.delete();
        exp_flag_q.delete();
        pend_valid = 1'b0;
        #1;
        check("arst_wr_en", 32'(reg_wr_en), 32'd0);
        check("arst_addr", 32'(reg_wr_addr), 32'd0);
        check("arst_data", 32'(reg_wr_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(mem_ready), 32'd1);
        check("arst_flags", 32'(flags_out), 32'd0);
        check("arst_ovf", 32'(overflow_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        reg_wr_ack = 1'b1;
        push(8'h9D, 4'b0010, 1'b1, 3'd6, 1'b0);
        check("post_rst_en", 32'(reg_wr_en), 32'd1);
        check("post_rst_data", 32'(reg_wr_data), 32'h9D);
        wait_idle(10);
        check("post_rst_flags", 32'(flags_out), 32'b0010);

        check("writes_left", 32'(exp_wr_q.size()), 32'd0);
        check("flags_left", 32'(exp_flag_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
